// File: rtl/sorter_pkg.sv
// Shared types and sizing for the 8-entry odd-even transposition sorter.
// Also holds the sequencer state encoding used by sorter_core.
package sorter_pkg;

  localparam int WIDTH    = 8;
  localparam int N_ELEM   = 8;
  localparam int N_PHASES = 8;
  localparam int PHASE_W  = 3;

  typedef logic [WIDTH-1:0] elem_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } sort_state_t;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(N_PHASES - 1);

  // Terminal-count compare for the phase counter.
  function automatic logic is_last_phase(input logic [PHASE_W-1:0] phase);
    return phase == LAST_PHASE;
  endfunction

endpackage

// File: rtl/sorter_if.sv
// Load/operand/result bundle between a sorter client (master) and sorter_core (slave).
interface sorter_if;
  import sorter_pkg::*;

  logic  load;
  elem_t in0, in1, in2, in3, in4, in5, in6, in7;
  logic  sorted;
  elem_t out0, out1, out2, out3, out4, out5, out6, out7;

  modport master (
    output load, in0, in1, in2, in3, in4, in5, in6, in7,
    input  sorted, out0, out1, out2, out3, out4, out5, out6, out7
  );

  modport slave (
    input  load, in0, in1, in2, in3, in4, in5, in6, in7,
    output sorted, out0, out1, out2, out3, out4, out5, out6, out7
  );

endinterface

// File: rtl/sorter_cas.sv
// Combinational unsigned compare-and-swap: lo = min, hi = max.
// Ties keep the original order (lo takes a), so equal keys never move.
module sorter_cas
  import sorter_pkg::*;
(
  input  elem_t a,
  input  elem_t b,
  output elem_t lo,
  output elem_t hi
);

  logic swap;

  assign swap = a > b;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/sorter_core.sv
// Sequential 8-entry ascending sorter: one odd-even transposition phase per clock,
// fixed 8-phase latency after load, result held until the next load or reset.
//
// state   | meaning
// ST_IDLE | after reset, no result yet (sorted=0)
// ST_BUSY | applying compare-exchange phases, phase counter advancing
// ST_DONE | all 8 phases applied, outputs frozen, sorted=1
module sorter_core
  import sorter_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  sorter_if.slave  sif
);

  sort_state_t          state_q, state_n;
  logic [PHASE_W-1:0]   phase_q, phase_n;
  elem_t                d_q    [N_ELEM];
  elem_t                d_n    [N_ELEM];
  elem_t                in_v   [N_ELEM];
  elem_t                even_v [N_ELEM];
  elem_t                odd_v  [N_ELEM];

  assign in_v[0] = sif.in0;
  assign in_v[1] = sif.in1;
  assign in_v[2] = sif.in2;
  assign in_v[3] = sif.in3;
  assign in_v[4] = sif.in4;
  assign in_v[5] = sif.in5;
  assign in_v[6] = sif.in6;
  assign in_v[7] = sif.in7;

  // Even phase: pairs (0,1)(2,3)(4,5)(6,7).
  for (genvar g = 0; g < N_ELEM / 2; g++) begin : g_even
    sorter_cas u_cas (
      .a  (d_q[2*g]),
      .b  (d_q[2*g+1]),
      .lo (even_v[2*g]),
      .hi (even_v[2*g+1])
    );
  end

  // Odd phase: pairs (1,2)(3,4)(5,6); the end elements pass through.
  assign odd_v[0]        = d_q[0];
  assign odd_v[N_ELEM-1] = d_q[N_ELEM-1];
  for (genvar g = 0; g < N_ELEM / 2 - 1; g++) begin : g_odd
    sorter_cas u_cas (
      .a  (d_q[2*g+1]),
      .b  (d_q[2*g+2]),
      .lo (odd_v[2*g+1]),
      .hi (odd_v[2*g+2])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      for (int i = 0; i < N_ELEM; i++) d_q[i] <= '0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      for (int i = 0; i < N_ELEM; i++) d_q[i] <= d_n[i];
    end
  end

  // A load always wins, so a load mid-sort simply restarts the sequence.
  always_comb begin
    state_n = state_q;
    phase_n = phase_q;
    for (int i = 0; i < N_ELEM; i++) d_n[i] = d_q[i];

    if (sif.load) begin
      for (int i = 0; i < N_ELEM; i++) d_n[i] = in_v[i];
      phase_n = '0;
      state_n = ST_BUSY;
    end else if (state_q == ST_BUSY) begin
      for (int i = 0; i < N_ELEM; i++) d_n[i] = phase_q[0] ? odd_v[i] : even_v[i];
      phase_n = phase_q + PHASE_W'(1);
      if (is_last_phase(phase_q)) state_n = ST_DONE;
    end
  end

  assign sif.sorted = (state_q == ST_DONE);
  assign sif.out0   = d_q[0];
  assign sif.out1   = d_q[1];
  assign sif.out2   = d_q[2];
  assign sif.out3   = d_q[3];
  assign sif.out4   = d_q[4];
  assign sif.out5   = d_q[5];
  assign sif.out6   = d_q[6];
  assign sif.out7   = d_q[7];

endmodule

// File: tb/tb_sorter_core.sv
// Directed plus randomized bench for sorter_core; expected results come from a
// plain insertion-sort reference and a fixed 8-cycle latency rule.
module tb_sorter_core;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  sorter_if sif ();

  sorter_core dut (
    .clock (clock),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] cur_out();
    return {sif.out7, sif.out6, sif.out5, sif.out4, sif.out3, sif.out2, sif.out1, sif.out0};
  endfunction

  // Reference: ascending order of the eight bytes, byte 0 = smallest.
  function automatic logic [63:0] ref_sort(input logic [63:0] p);
    int a[8];
    int t;
    int j;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) a[i] = int'(p[8*i +: 8]);
    for (int i = 1; i < 8; i++) begin
      t = a[i];
      j = i - 1;
      while (j >= 0 && a[j] > t) begin
        a[j+1] = a[j];
        j--;
      end
      a[j+1] = t;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(a[i]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [63:0] p);
    sif.in0 = p[7:0];
    sif.in1 = p[15:8];
    sif.in2 = p[23:16];
    sif.in3 = p[31:24];
    sif.in4 = p[39:32];
    sif.in5 = p[47:40];
    sif.in6 = p[55:48];
    sif.in7 = p[63:56];
  endtask

  task automatic do_load(input logic [63:0] p);
    set_in(p);
    sif.load = 1'b1;
    tick();
    sif.load = 1'b0;
    chk("load_capture", cur_out(), p);
    chk("load_sorted_low", 64'(sif.sorted), 64'(0));
  endtask

  // Load p, then expect sorted=0 for 7 edges and the full result on edge 8.
  task automatic run_sort(input string tag, input logic [63:0] p, input bit frozen);
    logic [63:0] exp;
    exp = ref_sort(p);
    do_load(p);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk({tag, "_sorted"}, 64'(sif.sorted), 64'(k == 8));
      if (frozen) chk({tag, "_frozen"}, cur_out(), p);
      if (k < 8) chk({tag, "_multiset"}, ref_sort(cur_out()), exp);
      else       chk({tag, "_result"}, cur_out(), exp);
    end
  endtask

  function automatic logic [63:0] rand_vec(input bit narrow);
    logic [63:0] r;
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom);
    return r;
  endfunction

  initial begin
    logic [63:0] v;
    logic [63:0] exp;

    sif.load = 1'b0;
    set_in('0);
    #1 reset = 1'b1;
    #1;
    chk("reset_out", cur_out(), '0);
    chk("reset_sorted", 64'(sif.sorted), 64'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick();
    chk("idle_sorted", 64'(sif.sorted), 64'(0));

    // 1: reversed input
    run_sort("rev", {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, 1'b0);
    chk("rev_const", cur_out(), {8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00});

    // 2: already sorted, outputs never move
    run_sort("presorted", {8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10}, 1'b1);

    // 3: duplicates and unsigned extremes
    run_sort("dups", {8'h80, 8'h00, 8'h01, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'hFF}, 1'b0);
    chk("dups_const", cur_out(), {8'hFF, 8'hFF, 8'h80, 8'h80, 8'h7F, 8'h01, 8'h00, 8'h00});

    // 4: abort by a second load three cycles into a sort
    do_load(rand_vec(1'b0));
    repeat (3) begin
      tick();
      chk("abort_pre_sorted", 64'(sif.sorted), 64'(0));
    end
    run_sort("abort", {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 1'b0);
    chk("abort_const", cur_out(), {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});

    // 6: result stays frozen with load low
    exp = cur_out();
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("hold_out", cur_out(), exp);
      chk("hold_sorted", 64'(sif.sorted), 64'(1));
    end

    // 5: reset mid-sort
    do_load(rand_vec(1'b0));
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("midreset_out", cur_out(), '0);
    chk("midreset_sorted", 64'(sif.sorted), 64'(0));
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("postreset_sorted", 64'(sif.sorted), 64'(0));
      chk("postreset_out", cur_out(), '0);
    end
    run_sort("after_reset", rand_vec(1'b0), 1'b0);

    // load held high across several edges: only the last capture is sorted
    for (int k = 0; k < 2; k++) begin
      v = rand_vec(1'b0);
      set_in(v);
      sif.load = 1'b1;
      tick();
      chk("held_capture", cur_out(), v);
      chk("held_sorted", 64'(sif.sorted), 64'(0));
    end
    run_sort("held_last", rand_vec(1'b0), 1'b0);

    // randomized sorts, alternating full-range and duplicate-heavy data
    for (int it = 0; it < 16; it++) begin
      run_sort("rand", rand_vec(it[0]), 1'b0);
      repeat (int'($urandom_range(0, 3))) begin
        tick();
        chk("rand_idle_sorted", 64'(sif.sorted), 64'(1));
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
